// File: rtl/multiplier_pkg.sv
// Shared constants for the pipelined unsigned multiplier: default operand
// width, derived half/product widths and the pipeline depth.
package multiplier_pkg;

   localparam int unsigned WIDTH_DEF = 16;
   localparam int unsigned HALF      = WIDTH_DEF / 2;
   localparam int unsigned PROD_W    = 2 * WIDTH_DEF;
   localparam int unsigned LATENCY   = 2;

   // Zero-extend a WIDTH_DEF-bit partial product and place it at bit offset sh.
   function automatic logic [PROD_W-1:0] place_pp(input logic [WIDTH_DEF-1:0] pp,
                                                  input int unsigned sh);
      logic [PROD_W-1:0] ext_s;
      ext_s    = '0;
      ext_s    = {{WIDTH_DEF{1'b0}}, pp};
      place_pp = ext_s << sh;
   endfunction

endpackage

// File: rtl/multiplier_mul_half.sv
// Unsigned W x W combinational multiplier producing a full 2*W-bit product;
// the top builds its wide product from four of these.
module mul_half
   import multiplier_pkg::*;
#(
   parameter int unsigned W = HALF
) (
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic [2*W-1:0] p
);

   logic [2*W-1:0] a_ext_s;
   logic [2*W-1:0] b_ext_s;

   assign a_ext_s = {{W{1'b0}}, a};
   assign b_ext_s = {{W{1'b0}}, b};
   assign p       = a_ext_s * b_ext_s;

endmodule

// File: rtl/multiplier.sv
// Two-stage pipelined unsigned multiplier: stage 1 registers four half-width
// partial products, stage 2 registers their shifted sum. One pair per cycle.
module multiplier
   import multiplier_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic [2*WIDTH-1:0] result,
   output logic               out_valid
);

   localparam int unsigned HW = WIDTH / 2;
   localparam int unsigned PW = 2 * WIDTH;

   logic [HW-1:0]    a_lo_s, a_hi_s, b_lo_s, b_hi_s;
   logic [WIDTH-1:0] pp_ll_s, pp_lh_s, pp_hl_s, pp_hh_s;
   logic [WIDTH-1:0] pp_ll_r, pp_lh_r, pp_hl_r, pp_hh_r;
   logic [LATENCY-1:0] vld_r;
   logic [PW-1:0]    sum_s;
   logic [PW-1:0]    result_r;

   assign a_lo_s = a[HW-1:0];
   assign a_hi_s = a[WIDTH-1:HW];
   assign b_lo_s = b[HW-1:0];
   assign b_hi_s = b[WIDTH-1:HW];

   mul_half #(.W(HW)) u_mul_ll (.a(a_lo_s), .b(b_lo_s), .p(pp_ll_s));
   mul_half #(.W(HW)) u_mul_lh (.a(a_lo_s), .b(b_hi_s), .p(pp_lh_s));
   mul_half #(.W(HW)) u_mul_hl (.a(a_hi_s), .b(b_lo_s), .p(pp_hl_s));
   mul_half #(.W(HW)) u_mul_hh (.a(a_hi_s), .b(b_hi_s), .p(pp_hh_s));

   // Stage 1: capture partial products of an accepted pair and shift the valid pipe.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pp_ll_r <= '0;
         pp_lh_r <= '0;
         pp_hl_r <= '0;
         pp_hh_r <= '0;
         vld_r   <= '0;
      end else begin
         vld_r <= {vld_r[LATENCY-2:0], in_valid};
         if (in_valid) begin
            pp_ll_r <= pp_ll_s;
            pp_lh_r <= pp_lh_s;
            pp_hl_r <= pp_hl_s;
            pp_hh_r <= pp_hh_s;
         end else begin
            pp_ll_r <= pp_ll_r;
            pp_lh_r <= pp_lh_r;
            pp_hl_r <= pp_hl_r;
            pp_hh_r <= pp_hh_r;
         end
      end
   end

   // Align and add the four partial products (cross terms share the HW offset).
   always_comb begin
      sum_s = '0;
      sum_s = PW'(place_pp(WIDTH_DEF'(pp_ll_r), 0))
            + PW'(place_pp(WIDTH_DEF'(pp_lh_r), HW))
            + PW'(place_pp(WIDTH_DEF'(pp_hl_r), HW))
            + PW'(place_pp(WIDTH_DEF'(pp_hh_r), WIDTH));
   end

   // Stage 2: result only moves for a valid pair, so it holds across bubbles.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         result_r <= '0;
      end else if (vld_r[0]) begin
         result_r <= sum_s;
      end else begin
         result_r <= result_r;
      end
   end

   assign result    = result_r;
   assign out_valid = vld_r[LATENCY-1];

endmodule

// File: tb/tb_multiplier.sv
// Self-checking bench for multiplier: directed vectors with hand-computed
// products, a 2-deep reference pipeline for timing, and a random sweep.
module tb_multiplier;
   import multiplier_pkg::*;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              in_valid;
   logic [15:0]       a, b;
   logic [PROD_W-1:0] result;
   logic              out_valid;

   int n_checks = 0;
   int n_errors = 0;

   logic        ev0 = 1'b0, ev1 = 1'b0;
   logic [31:0] ed0 = 32'd0, ed1 = 32'd0;
   logic [31:0] last_res = 32'd0;

   multiplier #(.WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
      .a(a), .b(b), .result(result), .out_valid(out_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Drive one cycle, advance the reference pipeline, then check outputs.
   task automatic tick(input logic rst, input logic v, input logic [15:0] x,
                       input logic [15:0] y, input logic [31:0] e, input string tag);
      rst_n = rst; in_valid = v; a = x; b = y;
      @(posedge clk);
      if (!rst) begin
         ev0 = 1'b0; ev1 = 1'b0; ed0 = 32'd0; ed1 = 32'd0; last_res = 32'd0;
      end else begin
         ev1 = ev0; ed1 = ed0;
         ev0 = v;   ed0 = e;
      end
      #1;
      chk({tag, "_ovld"}, {63'd0, out_valid}, {63'd0, ev1});
      if (ev1) begin
         chk({tag, "_res"}, {32'd0, result}, {32'd0, ed1});
         last_res = ed1;
      end else begin
         chk({tag, "_hold"}, {32'd0, result}, {32'd0, last_res});
      end
   endtask

   typedef struct { logic [15:0] x; logic [15:0] y; logic [31:0] p; } vec_t;
   vec_t vecs[10];

   initial begin
      vecs[0] = '{16'd17,    16'd16,    32'd272};
      vecs[1] = '{16'd13,    16'd5,     32'd65};
      vecs[2] = '{16'd11,    16'd15,    32'd165};
      vecs[3] = '{16'd512,   16'd900,   32'd460800};
      vecs[4] = '{16'd897,   16'd845,   32'd757965};
      vecs[5] = '{16'd1758,  16'd2022,  32'd3554676};
      vecs[6] = '{16'd1988,  16'd1900,  32'd3777200};
      vecs[7] = '{16'd65535, 16'd65535, 32'd4294836225};
      vecs[8] = '{16'd0,     16'd65535, 32'd0};
      vecs[9] = '{16'd65535, 16'd1,     32'd65535};

      // Reset, with a pair offered that must be ignored.
      tick(1'b0, 1'b1, 16'd7, 16'd9, 32'd0, "rst0");
      tick(1'b0, 1'b1, 16'd7, 16'd9, 32'd0, "rst1");
      tick(1'b1, 1'b0, 16'd0, 16'd0, 32'd0, "idle");

      // Back-to-back directed products followed by a drain.
      for (int i = 0; i < 10; i++)
         tick(1'b1, 1'b1, vecs[i].x, vecs[i].y, vecs[i].p, "dir");
      for (int i = 0; i < 3; i++)
         tick(1'b1, 1'b0, 16'd0, 16'd0, 32'd0, "drain");

      // Single pair then a gap: one pulse, result held afterwards.
      tick(1'b1, 1'b1, 16'd2000, 16'd1952, 32'd3904000, "gap");
      for (int i = 0; i < 3; i++)
         tick(1'b1, 1'b0, 16'd5, 16'd5, 32'd0, "gap_idle");
      chk("gap_held", {32'd0, result}, 64'd3904000);

      // Reset mid-flight: the in-flight product must never surface.
      tick(1'b1, 1'b1, 16'd999, 16'd888, 32'd887112, "mid");
      tick(1'b0, 1'b0, 16'd0, 16'd0, 32'd0, "mid_rst");
      chk("mid_res_zero", {32'd0, result}, 64'd0);
      for (int i = 0; i < 3; i++)
         tick(1'b1, 1'b0, 16'd0, 16'd0, 32'd0, "post_rst");
      tick(1'b1, 1'b1, 16'd3, 16'd4, 32'd12, "first_after");
      tick(1'b1, 1'b0, 16'd0, 16'd0, 32'd0, "first_after_w");
      tick(1'b1, 1'b0, 16'd0, 16'd0, 32'd0, "first_after_o");

      // Random sweep with random valid gaps.
      for (int i = 0; i < 10000; i++) begin
         logic [15:0] rx, ry;
         logic        rv;
         logic [31:0] rp;
         rx = 16'($urandom);
         ry = 16'($urandom);
         rv = ($urandom_range(0, 3) != 0);
         rp = 32'(rx) * 32'(ry);
         tick(1'b1, rv, rx, ry, rp, "rnd");
      end
      tick(1'b1, 1'b0, 16'd0, 16'd0, 32'd0, "rnd_drain0");
      tick(1'b1, 1'b0, 16'd0, 16'd0, 32'd0, "rnd_drain1");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
